keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 keypad and its scan datapath. It drives the rows one at a time and waits a settle interval before sampling the synchronized columns. It freezes the scan on a detected key, debounces press and release, and queues one key-event per debounced press into a small FIFO. Downstream consumers, such as the two-digit display register or a command decoder, pull events with a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 8191, cycles each row is driven before columns are sampled (must be >=3 to cover sync latency)
DEBOUNCE_CYCLES, 1048576, cycles a press or release must be stable before it is accepted
FIFO_DEPTH, 4, key-event queue depth (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
scan_en  in  1  1 = scanning enabled; 0 = rows released, FSM parked
cols  in  4  raw keypad columns, asynchronous, active-high
rows  out  4  one-hot row drive, 0 when idle
key_valid  out  1  FIFO head holds an event
key_code  out  4  hex value of FIFO head (0 when empty)
key_ready  in  1  consumer accepts head when key_valid & key_ready
key_held  out  1  1 while FSM in PRESSED or RELEASE
overflow  out  1  sticky: an event was dropped on a full FIFO
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, async): state IDLE, row index 0, counters 0, FIFO empty, rows=0, key_valid=0, key_code=0, key_held=0, overflow=0.
- cols pass through a 2-flop synchronizer (cols_s). All decisions use cols_s only.
- Decode: highest set column bit wins. Map by row/col3..0:
  - row0 = A,3,2,1
  - row1 = B,6,5,4
  - row2 = C,9,8,7
  - row3 = D,F,0,E
  - cols_s=0 means no key.
- States (enum): IDLE, SCAN, CONFIRM, PRESSED, RELEASE.
- IDLE: rows=0. If scan_en=1, go to SCAN on the next cycle, row 0, cnt=0.
- SCAN: rows=1<<row. cnt increments. When cnt==SETTLE_CYCLES-1:
  - cols_s!=0: latch code, go to CONFIRM, cnt=0.
  - cols_s=0: row=row+1 mod 4 (3 wraps to 0), cnt=0.
- CONFIRM: same row held. Any cycle where decoded code != latched code (including zero) returns to SCAN on the same row, cnt=0. At cnt==DEBOUNCE_CYCLES-1 go to PRESSED and push the latched code.
- PRESSED: row held. cols_s==0 goes to RELEASE, cnt=0. A different nonzero code stays in PRESSED with no event (no rollover).
- RELEASE: cols_s!=0 returns to PRESSED with no event. At cnt==DEBOUNCE_CYCLES-1 go to SCAN with the next row, cnt=0.
- scan_en=0 in any state: IDLE next cycle, counters cleared, any in-progress press discarded. FIFO contents and overflow are retained.
- FIFO:
  - push registered; key_valid rises the cycle after a push into an empty FIFO; head stable until popped.
  - Pop on key_valid & key_ready.
  - Push when full and no pop: event dropped, overflow=1.
  - Push and pop in the same cycle when full: both occur, no drop.
  - Push and pop in the same cycle when empty: not possible, since key_valid=0.
- overflow_clr and a drop in the same cycle: overflow stays 1 (set wins).
- Counter widths are $clog2 of the respective parameter. Counters saturate at the terminal value and never wrap.

Optional Feature:
KEY_RELEASE_EVT_EN. When defined:
- FIFO width grows by 1 and a key_release output (1 bit, FIFO head) is added.
- A RELEASE->SCAN completion pushes {release=1, latched code}.
- Press events carry release=0.
When undefined, only press events exist and the port is absent.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum
  - key code constants KEY_0..KEY_F
  - function key_decode(row index, cols) returning {hit, code[3:0]}
- Sub-module key_event_fifo (parameterised width/depth, push/pop/full/empty, registered head) instantiated once.
- The FSM, synchronizer and counters stay in keypad_scan_ctrl.

Test Plan:
Benches use SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=16.
1. Reset low then high, scan_en=1, cols=0 -> rows cycles 0001,0010,0100,1000,0001, each held exactly 4 cycles; key_valid stays 0.
2. Hold cols=0010 while rows=0100 for 40 cycles, then release -> exactly one event, key_code=8, key_valid set 1 cycle after CONFIRM expires. Scan resumes at rows=1000 after 16 stable-zero cycles.
3. Bounce: during CONFIRM toggle cols 0001/0000 every 3 cycles for 30 cycles on row 3, then stable 0001 -> one event key_code=E only. Repeating the bounce during RELEASE produces no extra event.
4. key_ready=0, press keys 1,5,9,C,0 sequentially -> FIFO holds 1,5,9,C and overflow=1. Then key_ready=1 -> pops 1,5,9,C in order, key_valid falls. overflow_clr -> 0.
5. cols=1001 on row 1 -> key_code=B (highest column wins). Drop scan_en mid-CONFIRM -> rows=0 next cycle, no event, FIFO unchanged.
6. Assert reset (low) mid-PRESSED with 2 queued events -> all outputs 0 asynchronously. Scan restarts at row 0 after release. With KEY_RELEASE_EVT_EN, a single press of 7 yields {0,7} then {1,7}.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state type, key code constants and the row/column decode
// shared by the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      CONFIRM,
      PRESSED,
      RELEASE
   } scan_state_t;

   localparam logic [3:0] KEY_0 = 4'h0;
   localparam logic [3:0] KEY_1 = 4'h1;
   localparam logic [3:0] KEY_2 = 4'h2;
   localparam logic [3:0] KEY_3 = 4'h3;
   localparam logic [3:0] KEY_4 = 4'h4;
   localparam logic [3:0] KEY_5 = 4'h5;
   localparam logic [3:0] KEY_6 = 4'h6;
   localparam logic [3:0] KEY_7 = 4'h7;
   localparam logic [3:0] KEY_8 = 4'h8;
   localparam logic [3:0] KEY_9 = 4'h9;
   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   // Returns {hit, code}. The highest active column wins; hit=0 when no
   // column is active, in which case the code is forced to 0.
   function automatic logic [4:0] key_decode(input logic [1:0] row,
                                             input logic [3:0] cols);
      logic [1:0] col;
      logic [3:0] code;
      col  = 2'd0;
      code = KEY_0;
      if (cols[3])      col = 2'd3;
      else if (cols[2]) col = 2'd2;
      else if (cols[1]) col = 2'd1;
      else              col = 2'd0;
      case ({row, col})
         4'b00_11: code = KEY_A;
         4'b00_10: code = KEY_3;
         4'b00_01: code = KEY_2;
         4'b00_00: code = KEY_1;
         4'b01_11: code = KEY_B;
         4'b01_10: code = KEY_6;
         4'b01_01: code = KEY_5;
         4'b01_00: code = KEY_4;
         4'b10_11: code = KEY_C;
         4'b10_10: code = KEY_9;
         4'b10_01: code = KEY_8;
         4'b10_00: code = KEY_7;
         4'b11_11: code = KEY_D;
         4'b11_10: code = KEY_F;
         4'b11_01: code = KEY_0;
         default:  code = KEY_E;
      endcase
      if (cols == 4'b0000) code = KEY_0;
      return {|cols, code};
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: small synchronous FIFO for key events. The head is read
// straight from storage registers and reads as 0 while the FIFO is empty.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module key_event_fifo
   import keypad_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Qualify requests: a push into a full FIFO is accepted only alongside a pop.
   always_comb begin
      full    = (count == FULL_CNT);
      empty   = (count == '0);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      head    = empty ? '0 : mem[rd_ptr];
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with column synchronizer,
// press/release debounce and a key-event FIFO with valid/ready output.
// Optional macro KEY_RELEASE_EVT_EN: adds a release flag to each event
// (key_release port) and queues an event when a release is accepted.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES   = 8191,
   parameter int unsigned DEBOUNCE_CYCLES = 1048576,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_en,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overflow,
`ifdef KEY_RELEASE_EVT_EN
   output logic       key_release,
`endif
   input  logic       overflow_clr
);

   localparam int unsigned SW = $clog2(SETTLE_CYCLES);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] S_TERM = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_RELEASE_EVT_EN
   localparam int unsigned EVT_W = 5;
`else
   localparam int unsigned EVT_W = 4;
`endif

   logic [3:0]       cols_m;
   logic [3:0]       cols_s;
   scan_state_t      state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [SW-1:0]    scnt_q, scnt_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [3:0]       code_q, code_d;
   logic [4:0]       dec;
   logic             hit;
   logic [3:0]       dec_code;
   logic             push_press;
`ifdef KEY_RELEASE_EVT_EN
   logic             push_rel;
`endif
   logic             push_any;
   logic [EVT_W-1:0] evt_data;
   logic [EVT_W-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             drop;

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cols_m <= '0;
         cols_s <= '0;
      end else begin
         cols_m <= cols;
         cols_s <= cols_m;
      end
   end

   // FSM state, row index, counters and latched key code.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         scnt_q  <= '0;
         dcnt_q  <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         scnt_q  <= scnt_d;
         dcnt_q  <= dcnt_d;
         code_q  <= code_d;
      end
   end

   // Next-state logic: scan rows, confirm and debounce press and release.
   // Counters only advance below their terminal value, so they saturate.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      scnt_d     = scnt_q;
      dcnt_d     = dcnt_q;
      code_d     = code_q;
      push_press = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      push_rel   = 1'b0;
`endif
      dec      = key_decode(row_q, cols_s);
      hit      = dec[4];
      dec_code = dec[3:0];

      if (!scan_en) begin
         state_d = IDLE;
         row_d   = '0;
         scnt_d  = '0;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SCAN;
               row_d   = '0;
               scnt_d  = '0;
               dcnt_d  = '0;
            end
            SCAN: begin
               if (scnt_q == S_TERM) begin
                  scnt_d = '0;
                  if (hit) begin
                     code_d  = dec_code;
                     dcnt_d  = '0;
                     state_d = CONFIRM;
                  end else begin
                     row_d = row_q + 2'd1;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            CONFIRM: begin
               if (!hit || (dec_code != code_q)) begin
                  state_d = SCAN;
                  scnt_d  = '0;
                  dcnt_d  = '0;
               end else if (dcnt_q == D_TERM) begin
                  state_d    = PRESSED;
                  dcnt_d     = '0;
                  push_press = 1'b1;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!hit) begin
                  state_d = RELEASE;
                  dcnt_d  = '0;
               end
            end
            RELEASE: begin
               if (hit) begin
                  state_d = PRESSED;
                  dcnt_d  = '0;
               end else if (dcnt_q == D_TERM) begin
                  state_d = SCAN;
                  row_d   = row_q + 2'd1;
                  scnt_d  = '0;
                  dcnt_d  = '0;
`ifdef KEY_RELEASE_EVT_EN
                  push_rel = 1'b1;
`endif
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               row_d   = '0;
               scnt_d  = '0;
               dcnt_d  = '0;
            end
         endcase
      end
   end

   // Row drive and held status decoded from the registered state.
   always_comb begin
      rows = 4'b0000;
      if (state_q != IDLE) rows = 4'b0001 << row_q;
      key_held = (state_q == PRESSED) || (state_q == RELEASE);
   end

   // Event formation and FIFO handshake; a drop only happens on a full FIFO
   // that is not being popped in the same cycle.
   always_comb begin
`ifdef KEY_RELEASE_EVT_EN
      push_any    = push_press | push_rel;
      evt_data    = {push_rel, code_q};
      key_release = fifo_head[4];
`else
      push_any    = push_press;
      evt_data    = code_q;
`endif
      key_valid = ~fifo_empty;
      key_code  = fifo_head[3:0];
      pop       = key_valid & key_ready;
      drop      = push_any & fifo_full & ~pop;
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   key_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_any),
      .push_data (evt_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed and randomized bench for keypad_scan_ctrl.
// A physical keypad model drives cols from rows; expected events come from
// the key table and a capacity-limited event queue.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

   localparam int SETTLE = 4;
   localparam int DEB    = 16;
   localparam int DEPTH  = 4;
   localparam int SYNC   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       scan_en;
   logic [3:0] cols;
   logic [3:0] rows;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_held;
   logic       overflow;
   logic       overflow_clr;
`ifdef KEY_RELEASE_EVT_EN
   logic       key_release;
`endif

   int checks = 0;
   int errors = 0;

   logic [1:0]  kp_row;
   logic [3:0]  kp_mask;
   logic [63:0] keytab;
   logic [4:0]  expq [$];
   logic        exp_ovf;

   always #5 clk = ~clk;

   // Pressed key closes the contacts between its row and the masked columns.
   always_comb cols = rows[kp_row] ? kp_mask : 4'b0000;

   keypad_scan_ctrl #(
      .SETTLE_CYCLES   (SETTLE),
      .DEBOUNCE_CYCLES (DEB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .scan_en      (scan_en),
      .cols         (cols),
      .rows         (rows),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .key_held     (key_held),
      .overflow     (overflow),
`ifdef KEY_RELEASE_EVT_EN
      .key_release  (key_release),
`endif
      .overflow_clr (overflow_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] exp_code(input int r, input logic [3:0] mask);
      int c;
      c = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) c = i;
      return keytab[(r*4 + c)*4 +: 4];
   endfunction

   task automatic model_push(input logic rel, input logic [3:0] code);
      if (expq.size() < DEPTH) expq.push_back({rel, code});
      else exp_ovf = 1'b1;
   endtask

   task automatic wait_held(input logic lvl, input string tag);
      int n;
      n = 0;
      while (key_held !== lvl && n < 400) begin @(negedge clk); n++; end
      chk(tag, key_held, lvl);
   endtask

   task automatic wait_rows(input logic [3:0] val, input string tag);
      int n;
      n = 0;
      while (rows !== val && n < 200) begin @(negedge clk); n++; end
      chk(tag, rows, val);
   endtask

   task automatic wait_rows_not(input logic [3:0] val, input string tag);
      int n;
      n = 0;
      while (rows === val && n < 200) begin @(negedge clk); n++; end
      chk(tag, rows !== val, 1'b1);
   endtask

   // One complete keystroke: press until accepted, hold a little, release.
   task automatic press(input int r, input logic [3:0] mask);
      kp_row  = r[1:0];
      kp_mask = mask;
      wait_held(1'b1, "press_held");
      if (key_held === 1'b1) model_push(1'b0, exp_code(r, mask));
      cyc(2 + int'($urandom_range(0, 8)));
      kp_mask = 4'b0000;
      wait_held(1'b0, "release_done");
`ifdef KEY_RELEASE_EVT_EN
      model_push(1'b1, exp_code(r, mask));
`endif
   endtask

   // Pop everything, comparing each head against the model queue.
   task automatic drain(input string tag);
      int guard;
      logic [4:0] obs;
      logic [4:0] want;
      guard = 0;
      key_ready = 1'b1;
      while (key_valid === 1'b1 && guard < 16) begin
         obs = {1'b0, key_code};
`ifdef KEY_RELEASE_EVT_EN
         obs[4] = key_release;
`endif
         if (expq.size() == 0) begin
            chk({tag, "_unexpected"}, key_valid, 1'b0);
         end else begin
            want = expq.pop_front();
            chk(tag, obs, want);
         end
         @(negedge clk);
         guard++;
      end
      key_ready = 1'b0;
      chk({tag, "_missing"}, expq.size(), 0);
      chk({tag, "_empty"}, key_valid, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int run;
      int r;
      logic [3:0] m;
      logic [3:0] oh;
      logic       seen_valid;
      logic [4:0] head0;

      keytab = 64'hDF0E_C987_B654_A321;
      reset = 1'b0; scan_en = 1'b0; kp_row = 2'd0; kp_mask = 4'b0000;
      key_ready = 1'b0; overflow_clr = 1'b0; exp_ovf = 1'b0;
      cyc(3);

      // Reset state
      chk("rst_rows", rows, 4'b0000);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_code", key_code, 4'h0);
      chk("rst_held", key_held, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      reset = 1'b1;
      scan_en = 1'b1;

      // Idle scan: each row held SETTLE cycles, wrap to row 0
      n = 0;
      while (rows === 4'b0000 && n < 10) begin cyc(1); n++; end
      chk("scan_start", rows, 4'b0001);
      seen_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         oh = 4'b0001 << i;
         run = 0;
         while (rows === oh && run < 20) begin
            seen_valid |= key_valid;
            run++;
            cyc(1);
         end
         chk("row_hold", run, SETTLE);
      end
      chk("row_wrap", rows, 4'b0001);
      chk("scan_no_evt", seen_valid, 1'b0);

      // Key 8: valid exactly SETTLE+DEBOUNCE cycles after its row slot starts
      kp_row = 2'd2; kp_mask = 4'b0010;
      wait_rows(4'b0100, "t2_row");
      n = 0;
      while (key_valid !== 1'b1 && n < 100) begin cyc(1); n++; end
      chk("t2_latency", n, SETTLE + DEB);
      chk("t2_code", key_code, exp_code(2, 4'b0010));
      chk("t2_held", key_held, 1'b1);
      model_push(1'b0, exp_code(2, 4'b0010));
      cyc(40 - n);
      kp_mask = 4'b0000;
      n = 0;
      while (rows !== 4'b1000 && n < 100) begin cyc(1); n++; end
      chk("t2_resume", n, SYNC + 1 + DEB);
      chk("t2_rel_held", key_held, 1'b0);
`ifdef KEY_RELEASE_EVT_EN
      model_push(1'b1, exp_code(2, 4'b0010));
`endif
      drain("t2");

      // Bounce on row 3 during confirm and during release
      kp_row = 2'd3; kp_mask = 4'b0000;
      wait_rows_not(4'b1000, "t3_leave");
      wait_rows(4'b1000, "t3_row");
      for (int i = 0; i < 10; i++) begin
         kp_mask = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         cyc(3);
      end
      kp_mask = 4'b0001;
      wait_held(1'b1, "t3_held");
      model_push(1'b0, exp_code(3, 4'b0001));
      cyc(5);
      for (int i = 0; i < 10; i++) begin
         kp_mask = (i % 2 == 0) ? 4'b0000 : 4'b0001;
         cyc(3);
      end
      kp_mask = 4'b0000;
      wait_held(1'b0, "t3_rel");
`ifdef KEY_RELEASE_EVT_EN
      model_push(1'b1, exp_code(3, 4'b0001));
`endif
      cyc(30);
      drain("t3");

      // Overflow: 1,5,9,C queued; key 0 lands on a full FIFO with a clear
      // pulse in the very same cycle
      key_ready = 1'b0;
      press(0, 4'b0001);
      press(1, 4'b0010);
      press(2, 4'b0100);
      press(2, 4'b1000);
      kp_row = 2'd3; kp_mask = 4'b0000;
      wait_rows_not(4'b1000, "t4_leave");
      kp_mask = 4'b0010;
      wait_rows(4'b1000, "t4_row");
      cyc(SETTLE + DEB - 1);
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      chk("t4_set_wins", overflow, 1'b1);
      chk("t4_held", key_held, 1'b1);
      model_push(1'b0, exp_code(3, 4'b0010));
      cyc(3);
      kp_mask = 4'b0000;
      wait_held(1'b0, "t4_rel");
`ifdef KEY_RELEASE_EVT_EN
      model_push(1'b1, exp_code(3, 4'b0010));
`endif
      chk("t4_ovf", overflow, exp_ovf);
      drain("t4");
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      exp_ovf = 1'b0;
      chk("t4_ovf_clr", overflow, 1'b0);

      // Highest column wins; scan_en drop mid-confirm discards the press
      press(1, 4'b1001);
      kp_row = 2'd2; kp_mask = 4'b0000;
      wait_rows_not(4'b0100, "t5_leave");
      kp_mask = 4'b0001;
      wait_rows(4'b0100, "t5_row");
      cyc(SETTLE + 5);
      scan_en = 1'b0;
      cyc(1);
      chk("t5_rows_off", rows, 4'b0000);
      chk("t5_held", key_held, 1'b0);
      cyc(DEB + 10);
      head0 = expq[0];
      chk("t5_rows_idle", rows, 4'b0000);
      chk("t5_valid_kept", key_valid, 1'b1);
      chk("t5_head_kept", key_code, head0[3:0]);
      kp_mask = 4'b0000;
      scan_en = 1'b1;
      wait_rows_not(4'b0000, "t5_wake");
      chk("t5_restart", rows, 4'b0001);
      drain("t5");

      // Asynchronous reset while a key is held with events queued
      key_ready = 1'b0;
      press(0, 4'b0100);
      press(1, 4'b0001);
      kp_row = 2'd2; kp_mask = 4'b0001;
      wait_held(1'b1, "t6_held");
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rows", rows, 4'b0000);
      chk("t6_valid", key_valid, 1'b0);
      chk("t6_code", key_code, 4'h0);
      chk("t6_keyheld", key_held, 1'b0);
      chk("t6_ovf", overflow, 1'b0);
      expq.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      kp_mask = 4'b0000;
      reset = 1'b1;
      wait_rows_not(4'b0000, "t6_wake");
      chk("t6_restart", rows, 4'b0001);
      press(2, 4'b0001);
      drain("t6_seven");

      // Randomized keystrokes with occasional draining and clearing
      for (int k = 0; k < 12; k++) begin
         r = int'($urandom_range(0, 3));
         m = 4'($urandom_range(1, 15));
         press(r, m);
         if ($urandom_range(0, 1) == 1) begin
            chk("rnd_ovf", overflow, exp_ovf);
            drain("rnd");
            overflow_clr = 1'b1;
            cyc(1);
            overflow_clr = 1'b0;
            exp_ovf = 1'b0;
         end
      end
      chk("rnd_ovf_end", overflow, exp_ovf);
      drain("rnd_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
